// File: rtl/ne_fp_ffp_align_mw33.sv
// FFP right-shift alignment stage.
// Arithmetically shifts the two's-complement mantissa of an FFP operand
// {status, sign, exp, mant} right until its exponent equals tgt_e, and
// reports a sticky OR of the discarded bits. Two register stages share a
// single advance enable, so the whole pipe moves or holds together.
module ne_fp_ffp_align_mw33 #(
  parameter int SW        = 1,
  parameter int EW        = 10,
  parameter int MW        = 33,
  parameter int BW_STATUS = 3,
  parameter int CLOG2_MW  = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BW_STATUS+SW+EW+MW-1:0]  a,
  input  logic [EW-1:0]                  tgt_e,
  input  logic [2:0]                     mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BW_STATUS+SW+EW+MW-1:0]  z,
  output logic                           sticky,
  output logic                           align_err
);

  // operand fields
  logic [BW_STATUS-1:0] a_st;
  logic [SW-1:0]        a_s;
  logic [EW-1:0]        a_e;
  logic [MW-1:0]        a_m;

  assign a_m  = a[MW-1:0];
  assign a_e  = a[MW+EW-1:MW];
  assign a_s  = a[MW+EW+SW-1:MW+EW];
  assign a_st = a[MW+EW+SW+BW_STATUS-1:MW+EW+SW];

  // mode[2:1] carry no function in this stage
  logic unused_mode;
  assign unused_mode = ^mode[2:1];

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // stage 1 combinational: exponent difference and shift amount
  logic signed [EW:0]   diff;
  logic                 diff_neg;
  logic                 diff_big;
  logic [CLOG2_MW-1:0]  shamt_n;
  logic [EW-1:0]        e_n;

  // diff is one bit wider than the exponents so tgt_e - a_e never wraps
  always_comb begin
    diff     = $signed({tgt_e[EW-1], tgt_e}) - $signed({a_e[EW-1], a_e});
    diff_neg = diff[EW];
    diff_big = (diff >= $signed((EW+1)'(MW)));
    shamt_n  = '0;
    e_n      = tgt_e;
    if (diff_neg) begin
      shamt_n = '0;
      e_n     = a_e;
    end else if (diff_big) begin
      shamt_n = CLOG2_MW'(MW);
    end else begin
      shamt_n = diff[CLOG2_MW-1:0];
    end
  end

  // stage 1 registers
  logic                 v1;
  logic [BW_STATUS-1:0] s1_st;
  logic [SW-1:0]        s1_sign;
  logic [EW-1:0]        s1_ae;
  logic [MW-1:0]        s1_m;
  logic [EW-1:0]        s1_tgt;
  logic                 s1_byp;
  logic [CLOG2_MW-1:0]  s1_shamt;
  logic                 s1_all;
  logic                 s1_err;
  logic [EW-1:0]        s1_e;

  // capture the operand and its alignment decision whenever the pipe advances
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_st    <= '0;
      s1_sign  <= '0;
      s1_ae    <= '0;
      s1_m     <= '0;
      s1_tgt   <= '0;
      s1_byp   <= 1'b0;
      s1_shamt <= '0;
      s1_all   <= 1'b0;
      s1_err   <= 1'b0;
      s1_e     <= '0;
    end else if (adv) begin
      v1       <= in_valid;
      s1_st    <= a_st;
      s1_sign  <= a_s;
      s1_ae    <= a_e;
      s1_m     <= a_m;
      s1_tgt   <= tgt_e;
      s1_byp   <= mode[0];
      s1_shamt <= shamt_n;
      s1_all   <= diff_big & ~diff_neg;
      s1_err   <= diff_neg;
      s1_e     <= e_n;
    end
  end

  // stage 2 combinational: shift, sticky, special-operand override
  logic [MW-1:0]                 m_sh;
  logic [MW:0]                   mask;
  logic [BW_STATUS+SW+EW+MW-1:0] z_n;
  logic                          sticky_n;
  logic                          err_n;

  // a full shift (shamt == MW) leaves only sign copies; mask then covers all bits
  always_comb begin
    if (s1_all) m_sh = {MW{s1_m[MW-1]}};
    else        m_sh = $signed(s1_m) >>> s1_shamt;
    mask     = ((MW+1)'(1) << s1_shamt) - (MW+1)'(1);
    z_n      = {{BW_STATUS{1'b0}}, s1_sign, s1_e, m_sh};
    sticky_n = |(s1_m & mask[MW-1:0]);
    err_n    = s1_err;
    if (s1_byp) begin
      z_n      = {{BW_STATUS{1'b0}}, s1_sign, s1_ae, s1_m};
      sticky_n = 1'b0;
      err_n    = 1'b0;
    end else if (s1_st[2]) begin
      z_n      = {3'b100, s1_sign, 1'b1, {(EW-1){1'b0}},
                  s1_sign[SW-1], s1_sign[SW-1], 1'b1, {(MW-3){1'b0}}};
      sticky_n = 1'b0;
      err_n    = 1'b0;
    end else if (s1_st[1]) begin
      z_n      = {3'b010, s1_sign, 1'b1, {(EW-1){1'b0}},
                  s1_sign[SW-1], s1_sign[SW-1], {(MW-2){1'b0}}};
      sticky_n = 1'b0;
      err_n    = 1'b0;
    end else if (s1_st[0]) begin
      z_n      = {3'b001, s1_sign, s1_tgt, {MW{1'b0}}};
      sticky_n = 1'b0;
      err_n    = 1'b0;
    end
  end

  // output stage: data only reloads on a valid operand so it holds across bubbles and stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      sticky    <= 1'b0;
      align_err <= 1'b0;
    end else if (adv) begin
      out_valid <= v1;
      if (v1) begin
        z         <= z_n;
        sticky    <= sticky_n;
        align_err <= err_n;
      end
    end
  end

endmodule
